// File: rtl/gpio_responder_pkg.sv
// Shared definitions for the GPIO responder: register offsets, store sizes
// and the byte-lane enable/alignment helpers used by the bus write path.
package gpio_responder_pkg;

    // Word offsets (Addr[4:2]) of the register map.
    localparam logic [2:0] RegModer    = 3'd0;
    localparam logic [2:0] RegIdr      = 3'd1;
    localparam logic [2:0] RegOdr      = 3'd2;
    localparam logic [2:0] RegEdgeEn   = 3'd3;
    localparam logic [2:0] RegEdgeStat = 3'd4;

    typedef enum logic [1:0] {
        StoreByte = 2'd0,
        StoreHalf = 2'd1,
        StoreWord = 2'd2,
        StoreRsvd = 2'd3
    } store_type_e;

    function automatic logic [3:0] lane_en(input store_type_e st, input logic [1:0] addr_lo);
        logic [3:0] en;
        en = 4'b0000;
        case (st)
            StoreByte: en = 4'b0001 << addr_lo;
            StoreHalf: en = addr_lo[1] ? 4'b1100 : 4'b0011;
            StoreWord: en = 4'b1111;
            default:   en = 4'b0000;
        endcase
        return en;
    endfunction

    // Right-aligned master data is replicated so every enabled lane sees it.
    function automatic logic [31:0] align_wdata(input store_type_e st, input logic [31:0] wdata);
        logic [31:0] al;
        case (st)
            StoreByte: al = {4{wdata[7:0]}};
            StoreHalf: al = {2{wdata[15:0]}};
            default:   al = wdata;
        endcase
        return al;
    endfunction

endpackage

// File: rtl/gpio_responder_if.sv
// Slave bus interface between the bus master and the GPIO responder.
interface gpio_responder_if;

    logic        sel;
    logic        dataMem_wr_en;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [1:0]  storeType;
    logic [31:0] SlaveRData;

    modport master (
        output sel,
        output dataMem_wr_en,
        output Addr,
        output WData,
        output storeType,
        input  SlaveRData
    );

    modport slave (
        input  sel,
        input  dataMem_wr_en,
        input  Addr,
        input  WData,
        input  storeType,
        output SlaveRData
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchronizer followed by a per-bit rising-edge detector.
module gpio_sync_edge #(
    parameter int unsigned PORT_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [PORT_W-1:0] gpio_i,
    output logic [PORT_W-1:0] idr_o,
    output logic [PORT_W-1:0] rise_o
);

    logic [PORT_W-1:0] sync1_q;
    logic [PORT_W-1:0] sync2_q;
    logic [PORT_W-1:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign idr_o  = sync2_q;
    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO block: direction/output registers, synchronized inputs,
// rising-edge capture with W1C status and a registered level interrupt.
module gpio_responder
    import gpio_responder_pkg::*;
#(
    parameter int unsigned PORT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    gpio_responder_if.slave     bus,
    input  logic [PORT_W-1:0]   gpio_in,
    output logic [PORT_W-1:0]   gpio_out,
    output logic [PORT_W-1:0]   gpio_oe,
    output logic                irq
);

    logic [PORT_W-1:0] moder_q, moder_d;
    logic [PORT_W-1:0] odr_q, odr_d;
    logic [PORT_W-1:0] edge_en_q, edge_en_d;
    logic [PORT_W-1:0] edge_stat_q, edge_stat_d;
    logic              irq_q, irq_d;

    logic [PORT_W-1:0] idr;
    logic [PORT_W-1:0] rise;

    store_type_e       st;
    logic [2:0]        reg_idx;
    logic              wr_active;
    logic [3:0]        lanes;
    logic [31:0]       wdata_al;
    logic [31:0]       bit_mask;
    logic [PORT_W-1:0] wmask;
    logic [PORT_W-1:0] wval;
    logic [PORT_W-1:0] w1c;
    logic [31:0]       rdata;
    logic              unused_bits;

    gpio_sync_edge #(
        .PORT_W (PORT_W)
    ) u_sync_edge (
        .clk_i   (clk),
        .reset_i (reset),
        .gpio_i  (gpio_in),
        .idr_o   (idr),
        .rise_o  (rise)
    );

    assign st        = store_type_e'(bus.storeType);
    assign reg_idx   = bus.Addr[4:2];
    assign wr_active = bus.sel & bus.dataMem_wr_en;
    assign wdata_al  = align_wdata(st, bus.WData);

    always_comb begin
        lanes = wr_active ? lane_en(st, bus.Addr[1:0]) : 4'b0000;
        for (int b = 0; b < 4; b++) begin
            bit_mask[8*b +: 8] = {8{lanes[b]}};
        end
    end

    // Lanes above PORT_W have no storage; those mask and data bits are dropped.
    assign wmask = bit_mask[PORT_W-1:0];
    assign wval  = wdata_al[PORT_W-1:0];
    assign unused_bits = ^{bus.Addr[31:5], wdata_al, bit_mask};

    always_comb begin
        moder_d   = moder_q;
        odr_d     = odr_q;
        edge_en_d = edge_en_q;
        w1c       = '0;
        case (reg_idx)
            RegModer:    moder_d   = (moder_q & ~wmask) | (wval & wmask);
            RegOdr:      odr_d     = (odr_q & ~wmask) | (wval & wmask);
            RegEdgeEn:   edge_en_d = (edge_en_q & ~wmask) | (wval & wmask);
            RegEdgeStat: w1c       = wval & wmask;
            default:     ;
        endcase
        // Set is applied after clear so a coincident edge wins over W1C.
        edge_stat_d = (edge_stat_q & ~w1c) | (rise & edge_en_q);
        irq_d       = |(edge_stat_q & edge_en_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            moder_q     <= '0;
            odr_q       <= '0;
            edge_en_q   <= '0;
            edge_stat_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            moder_q     <= moder_d;
            odr_q       <= odr_d;
            edge_en_q   <= edge_en_d;
            edge_stat_q <= edge_stat_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (bus.sel) begin
            case (reg_idx)
                RegModer:    rdata = 32'(moder_q);
                RegIdr:      rdata = 32'(idr);
                RegOdr:      rdata = 32'(odr_q);
                RegEdgeEn:   rdata = 32'(edge_en_q);
                RegEdgeStat: rdata = 32'(edge_stat_q);
                default:     rdata = 32'h0;
            endcase
        end
    end

    assign bus.SlaveRData = rdata;
    assign gpio_oe        = moder_q;
    assign gpio_out       = odr_q & moder_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_gpio_responder.sv
// Directed bench for gpio_responder: register-access vector table followed by
// hand-written edge/interrupt and reset sequences.
module tb_gpio_responder;

    logic       clk;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       irq;

    int total;
    int bad;

    gpio_responder_if bus ();

    gpio_responder #(
        .PORT_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wsel;
        logic        wen;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  st;
        logic        rsel;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_oe;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.sel           = 1'b0;
        bus.dataMem_wr_en = 1'b0;
        bus.Addr          = 32'h0;
        bus.WData         = 32'h0;
        bus.storeType     = 2'd2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
        bus.sel           = 1'b1;
        bus.dataMem_wr_en = 1'b1;
        bus.Addr          = a;
        bus.WData         = d;
        bus.storeType     = st;
        step();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.sel           = 1'b1;
        bus.dataMem_wr_en = 1'b0;
        bus.Addr          = a;
        #1;
        d = bus.SlaveRData;
    endtask

    initial begin
        logic [31:0] r;
        total = 0;
        bad   = 0;

        // wsel wen waddr wdata st rsel raddr exp_rd exp_oe exp_out
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 32'h0000_00F0, 2'd2, 1'b1, 32'h00, 32'hF0, 8'hF0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h08, 32'h0000_00AA, 2'd2, 1'b1, 32'h08, 32'hAA, 8'hF0, 8'hA0};
        vecs[2]  = '{1'b1, 1'b1, 32'h09, 32'h0000_0055, 2'd0, 1'b1, 32'h08, 32'hAA, 8'hF0, 8'hA0};
        vecs[3]  = '{1'b1, 1'b1, 32'h08, 32'h0000_0055, 2'd0, 1'b1, 32'h08, 32'h55, 8'hF0, 8'h50};
        vecs[4]  = '{1'b1, 1'b1, 32'h0A, 32'h0000_1234, 2'd1, 1'b1, 32'h08, 32'h55, 8'hF0, 8'h50};
        vecs[5]  = '{1'b1, 1'b1, 32'h08, 32'h0000_12C3, 2'd1, 1'b1, 32'h08, 32'hC3, 8'hF0, 8'hC0};
        vecs[6]  = '{1'b1, 1'b1, 32'h08, 32'h0000_00FF, 2'd3, 1'b1, 32'h08, 32'hC3, 8'hF0, 8'hC0};
        vecs[7]  = '{1'b1, 1'b1, 32'h04, 32'h0000_00FF, 2'd2, 1'b1, 32'h04, 32'h00, 8'hF0, 8'hC0};
        vecs[8]  = '{1'b1, 1'b1, 32'h14, 32'h0000_00FF, 2'd2, 1'b1, 32'h14, 32'h00, 8'hF0, 8'hC0};
        vecs[9]  = '{1'b0, 1'b1, 32'h00, 32'h0000_000F, 2'd2, 1'b0, 32'h00, 32'h00, 8'hF0, 8'hC0};
        vecs[10] = '{1'b1, 1'b1, 32'h03, 32'h0000_003C, 2'd2, 1'b1, 32'h00, 32'h3C, 8'h3C, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 32'h0C, 32'h0000_005A, 2'd0, 1'b1, 32'h0C, 32'h5A, 8'h3C, 8'h00};
        vecs[12] = '{1'b1, 1'b1, 32'h0E, 32'h0000_00A5, 2'd0, 1'b1, 32'h0C, 32'h5A, 8'h3C, 8'h00};
        vecs[13] = '{1'b1, 1'b1, 32'h0C, 32'h0000_0000, 2'd2, 1'b1, 32'h0C, 32'h00, 8'h3C, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 32'h00, 32'h0000_00FF, 2'd2, 1'b1, 32'h00, 32'h3C, 8'h3C, 8'h00};

        // Reset state
        gpio_in = 8'h00;
        reset   = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        rd(32'h00, r); chk("rst_moder", r, 32'h0);
        rd(32'h04, r); chk("rst_idr", r, 32'h0);
        rd(32'h08, r); chk("rst_odr", r, 32'h0);
        rd(32'h0C, r); chk("rst_edge_en", r, 32'h0);
        rd(32'h10, r); chk("rst_edge_stat", r, 32'h0);
        chk("rst_oe", 32'(gpio_oe), 32'h0);
        chk("rst_out", 32'(gpio_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        idle();

        // Register access table
        for (int i = 0; i < 15; i++) begin
            bus.sel           = vecs[i].wsel;
            bus.dataMem_wr_en = vecs[i].wen;
            bus.Addr          = vecs[i].waddr;
            bus.WData         = vecs[i].wdata;
            bus.storeType     = vecs[i].st;
            step();
            bus.sel           = vecs[i].rsel;
            bus.dataMem_wr_en = 1'b0;
            bus.Addr          = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_rdata", i), bus.SlaveRData, vecs[i].exp_rd);
            chk($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
            chk($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
        end
        idle();

        // Edge capture latency on bit 3
        wr(32'h0C, 32'h08, 2'd2);
        gpio_in = 8'h08;
        step();
        rd(32'h04, r); chk("edge_idr_c1", r, 32'h00);
        step();
        rd(32'h04, r); chk("edge_idr_c2", r, 32'h08);
        rd(32'h10, r); chk("edge_stat_c2", r, 32'h00);
        step();
        rd(32'h10, r); chk("edge_stat_c3", r, 32'h08);
        chk("edge_irq_c3", 32'(irq), 32'h0);
        step();
        chk("edge_irq_c4", 32'(irq), 32'h1);
        idle();

        // Clearing EDGE_EN keeps status but drops irq
        wr(32'h0C, 32'h00, 2'd2);
        rd(32'h10, r); chk("en_off_stat", r, 32'h08);
        chk("en_off_irq_c1", 32'(irq), 32'h1);
        step();
        chk("en_off_irq_c2", 32'(irq), 32'h0);
        idle();
        wr(32'h0C, 32'h08, 2'd2);
        chk("en_on_irq_c1", 32'(irq), 32'h0);
        step();
        chk("en_on_irq_c2", 32'(irq), 32'h1);

        // W1C coinciding with a new bit-3 edge: set wins
        gpio_in = 8'h00;
        step(); step(); step();
        gpio_in = 8'h08;
        step(); step();
        wr(32'h10, 32'h08, 2'd2);
        rd(32'h10, r); chk("race_stat_c1", r, 32'h08);
        chk("race_irq_c1", 32'(irq), 32'h1);
        step();
        rd(32'h10, r); chk("race_stat_c2", r, 32'h08);
        chk("race_irq_c2", 32'(irq), 32'h1);
        idle();

        // W1C with zero bits, then real clear
        wr(32'h10, 32'h00, 2'd2);
        rd(32'h10, r); chk("w1c_zero", r, 32'h08);
        idle();
        wr(32'h10, 32'h08, 2'd2);
        rd(32'h10, r); chk("w1c_clear", r, 32'h00);
        chk("w1c_irq_c1", 32'(irq), 32'h1);
        step();
        chk("w1c_irq_c2", 32'(irq), 32'h0);
        idle();

        // Mid-run reset with a simultaneous write
        wr(32'h0C, 32'h01, 2'd2);
        wr(32'h00, 32'hFF, 2'd2);
        gpio_in = 8'h09;
        step(); step(); step();
        rd(32'h10, r); chk("pre_rst_stat", r, 32'h01);
        chk("pre_rst_oe", 32'(gpio_oe), 32'hFF);
        reset             = 1'b1;
        bus.sel           = 1'b1;
        bus.dataMem_wr_en = 1'b1;
        bus.Addr          = 32'h00;
        bus.WData         = 32'h77;
        bus.storeType     = 2'd2;
        step();
        reset = 1'b0;
        idle();
        rd(32'h00, r); chk("mid_rst_moder", r, 32'h0);
        rd(32'h04, r); chk("mid_rst_idr", r, 32'h0);
        rd(32'h08, r); chk("mid_rst_odr", r, 32'h0);
        rd(32'h0C, r); chk("mid_rst_edge_en", r, 32'h0);
        rd(32'h10, r); chk("mid_rst_edge_stat", r, 32'h0);
        chk("mid_rst_oe", 32'(gpio_oe), 32'h0);
        chk("mid_rst_out", 32'(gpio_out), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        idle();
        step();
        rd(32'h04, r); chk("post_rst_idr_c1", r, 32'h00);
        idle();
        step();
        rd(32'h04, r); chk("post_rst_idr_c2", r, 32'h09);
        rd(32'h10, r); chk("post_rst_stat", r, 32'h00);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_responder.md
GPIO_RESPONDER -- requirements
Module: gpio_responder

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, named clk and reset.
REQ-002 Parameter SHALL be: PORT_W, default 8, GPIO pin count (1..32).
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port reset, input, 1 bit: synchronous active-high reset.
REQ-005 Port sel, input, 1 bit: chip select from the bus address decoder.
REQ-006 Port dataMem_wr_en, input, 1 bit: write strobe from the bus master.
REQ-007 Port Addr, input, 32 bits: byte address; bits [4:2] select the register, bits [1:0] select the byte lane.
REQ-008 Port WData, input, 32 bits: write data, right-aligned, as driven by the master.
REQ-009 Port storeType, input, 2 bits: store size, 0=byte, 1=half, 2=word, 3=reserved (no write).
REQ-010 Port SlaveRData, output, 32 bits: read data word.
REQ-011 Port gpio_in, input, PORT_W bits: asynchronous pin inputs.
REQ-012 Port gpio_out, output, PORT_W bits: pin output values.
REQ-013 Port gpio_oe, output, PORT_W bits: pin output enables, 1=drive.
REQ-014 Port irq, output, 1 bit: level interrupt request.

Function
REQ-015 The register map SHALL be (word offset): 0x00 MODER RW, 0x04 IDR RO, 0x08 ODR RW, 0x0C EDGE_EN RW, 0x10 EDGE_STAT W1C; 0x14..0x1C are reserved.
REQ-016 Each register SHALL be PORT_W bits wide in bits [PORT_W-1:0]; reads SHALL return 0 in bits above PORT_W.
REQ-017 SlaveRData SHALL be combinational from Addr[4:2] with zero latency; it SHALL be 0 when sel=0 or the offset is reserved.
REQ-018 A write SHALL occur on a clk edge only when sel=1 and dataMem_wr_en=1.
REQ-019 Byte lane enables SHALL be derived as follows:
- byte: lane Addr[1:0] is enabled and WData[7:0] is replicated to that lane.
- half: lanes {Addr[1],0} and {Addr[1],1} are enabled with WData[15:0].
- word: all lanes are enabled and Addr[1:0] is ignored.
REQ-020 Only enabled lanes SHALL update register bits; writes to IDR, to reserved offsets, and with storeType=3 SHALL be ignored.
REQ-021 gpio_oe SHALL equal MODER; gpio_out SHALL equal ODR & MODER.
REQ-022 gpio_in SHALL pass through a 2-flop synchronizer; IDR SHALL be the second stage, with a 2-cycle latency from pin to IDR.
REQ-023 A rising edge SHALL be detected when IDR is 1 and its previous-cycle value (prev) is 0; edge bit i SHALL set EDGE_STAT[i] when EDGE_EN[i]=1.
REQ-024 A write to EDGE_STAT SHALL clear the bits written as 1 in enabled lanes; bits written as 0 SHALL be unchanged.
REQ-025 If a set and a W1C occur on the same bit in the same cycle, the set SHALL win.
REQ-026 Clearing EDGE_EN[i] SHALL NOT clear EDGE_STAT[i].
REQ-027 irq SHALL be registered, equal to |(EDGE_STAT & EDGE_EN) one cycle after EDGE_STAT updates.

Reset
REQ-028 On reset, MODER, ODR, EDGE_EN, EDGE_STAT, both synchronizer stages, prev and irq SHALL be 0; gpio_oe and gpio_out therefore read 0.
REQ-029 Reset SHALL take priority over any simultaneous write or edge event.
REQ-030 No edge SHALL be reported in the first cycle after reset (prev=0, IDR=0).

Structure
REQ-031 A shared package SHALL hold the register offset constants, the storeType encoding enum, and the function that derives lane enables from storeType and Addr[1:0].
REQ-032 A sub-module gpio_sync_edge (synchronizer plus rising-edge detector, parameter PORT_W) SHALL be instantiated once.

Verification
REQ-033 Word write 0x0000_00F0 to 0x00, then word write 0x0000_00AA to 0x08 -> gpio_oe=0xF0, gpio_out=0xA0, read of 0x08 returns 0xAA.
REQ-034 Byte write 0x55 to Addr 0x09 (lane 1) after ODR=0xAA -> ODR remains 0xAA; byte write 0x55 to 0x08 -> ODR=0x55.
REQ-035 gpio_in bit 3 goes 0->1 at cycle N -> IDR[3]=1 by cycle N+2; with EDGE_EN=0x08, EDGE_STAT=0x08 at N+3 and irq=1 at N+4.
REQ-036 W1C 0x08 to 0x10 in the same cycle a new bit-3 edge is detected -> EDGE_STAT[3] stays 1 and irq stays 1.
REQ-037 Reset asserted for 1 cycle mid-operation with MODER=0xFF and EDGE_STAT=0x01 -> all registers, gpio_oe, gpio_out and irq read 0 on the next cycle.
REQ-038 Read of 0x14, or any read with sel=0 -> SlaveRData=0x0000_0000; a write to 0x04 -> IDR is unchanged.
